// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, oversampling constants
// and the parity helper used by both the RX and TX framing engines.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

  localparam int unsigned OVERSAMPLE    = 16;
  localparam int unsigned SAMPLE_W      = $clog2(OVERSAMPLE);
  localparam logic [SAMPLE_W-1:0] MID_SAMPLE = 4'd7;
  localparam int unsigned MAX_DATA_BITS = 9;

  // High when data bits plus the received parity bit disagree with the selected sense.
  function automatic logic parity_mismatch(input logic [MAX_DATA_BITS-1:0] bits,
                                           input logic                     sample,
                                           input logic                     odd);
    return (^bits) ^ sample ^ odd;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: counts 0..period and pulses tick_o on the wrap.
// A synchronous clear restarts the count and captures a new period.
module uart_baud_tick #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clear_i,
  input  logic [DIV_WIDTH-1:0] period_i,
  output logic                 tick_o
);

  logic [DIV_WIDTH-1:0] period_r;
  logic [DIV_WIDTH-1:0] count_r;

  // period capture and free-running divider
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      period_r <= {DIV_WIDTH{1'b0}};
      count_r  <= {DIV_WIDTH{1'b0}};
    end else if (clear_i) begin
      period_r <= period_i;
      count_r  <= {DIV_WIDTH{1'b0}};
    end else if (count_r == period_r) begin
      count_r  <= {DIV_WIDTH{1'b0}};
    end else begin
      count_r  <= count_r + {{(DIV_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign tick_o = (count_r == period_r);

endmodule

// File: rtl/uart_rx_frame.sv
// UART receive framing engine: 16x oversampled start detect, mid-bit sampling,
// optional parity, stop check, and a valid/ready word output with overrun report.
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int DIV_WIDTH  = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 rx_i,
  input  logic [DIV_WIDTH-1:0] baud_div_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 frame_err_o,
  output logic                 parity_err_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 overrun_o,
  output logic                 busy_o
);

  localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);
  localparam logic       ODD_SEL  = (PARITY_ODD != 0) ? 1'b1 : 1'b0;

  rx_state_e             state_r;
  rx_state_e             state_s;
  logic                  rx_prev_r;
  logic [SAMPLE_W-1:0]   sample_cnt_r;
  logic [3:0]            bit_idx_r;
  logic [DATA_BITS-1:0]  shift_r;
  logic [MAX_DATA_BITS-1:0] shift_ext_s;
  logic                  par_err_r;

  logic [DATA_BITS-1:0]  data_r;
  logic                  frame_err_r;
  logic                  parity_err_r;
  logic                  valid_r;
  logic                  overrun_r;
  logic                  busy_r;

  logic                  tick_s;
  logic                  start_det_s;
  logic                  mid_s;
  logic                  shift_en_s;
  logic                  par_en_s;
  logic                  stop_en_s;

  // Only a genuine high-to-low transition starts a frame, so a stuck-low line never retriggers.
  assign start_det_s = (state_r == IDLE) && rx_prev_r && !rx_i;
  assign mid_s       = tick_s && (sample_cnt_r == MID_SAMPLE);

  uart_baud_tick #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_baud_tick (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clear_i  (start_det_s),
    .period_i (baud_div_i),
    .tick_o   (tick_s)
  );

  // state register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // next-state decode and per-state sample strobes
  always_comb begin
    state_s    = state_r;
    shift_en_s = 1'b0;
    par_en_s   = 1'b0;
    stop_en_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (start_det_s) begin
          state_s = START;
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        if (mid_s) begin
          if (rx_i) begin
            state_s = IDLE;
          end else begin
            state_s = DATA;
          end
        end else begin
          state_s = START;
        end
      end
      DATA: begin
        if (mid_s) begin
          shift_en_s = 1'b1;
          if (bit_idx_r == LAST_BIT) begin
            state_s = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            state_s = DATA;
          end
        end else begin
          state_s = DATA;
        end
      end
      PARITY: begin
        if (mid_s) begin
          par_en_s = 1'b1;
          state_s  = STOP;
        end else begin
          state_s  = PARITY;
        end
      end
      STOP: begin
        if (mid_s) begin
          stop_en_s = 1'b1;
          state_s   = IDLE;
        end else begin
          state_s   = STOP;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // zero-extend the assembled word for the shared parity helper
  always_comb begin
    shift_ext_s                = {MAX_DATA_BITS{1'b0}};
    shift_ext_s[DATA_BITS-1:0] = shift_r;
  end

  // line history, oversample phase, bit index and data/parity capture
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_prev_r    <= 1'b1;
      sample_cnt_r <= {SAMPLE_W{1'b0}};
      bit_idx_r    <= 4'd0;
      shift_r      <= {DATA_BITS{1'b0}};
      par_err_r    <= 1'b0;
    end else begin
      rx_prev_r <= rx_i;

      if (start_det_s) begin
        sample_cnt_r <= {SAMPLE_W{1'b0}};
      end else if (tick_s && (state_r != IDLE)) begin
        sample_cnt_r <= sample_cnt_r + {{(SAMPLE_W-1){1'b0}}, 1'b1};
      end

      if (state_r == START) begin
        bit_idx_r <= 4'd0;
      end else if (shift_en_s) begin
        bit_idx_r <= bit_idx_r + 4'd1;
      end

      // LSB arrives first, so each new bit enters at the top and walks down
      if (shift_en_s) begin
        shift_r <= {rx_i, shift_r[DATA_BITS-1:1]};
      end

      if (start_det_s) begin
        par_err_r <= 1'b0;
      end else if (par_en_s) begin
        par_err_r <= parity_mismatch(shift_ext_s, rx_i, ODD_SEL);
      end
    end
  end

  // output word holding register, handshake and overrun reporting
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_r       <= {DATA_BITS{1'b0}};
      frame_err_r  <= 1'b0;
      parity_err_r <= 1'b0;
      valid_r      <= 1'b0;
      overrun_r    <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      overrun_r <= 1'b0;
      busy_r    <= (state_s != IDLE);
      if (stop_en_s) begin
        // a word being accepted this cycle frees the slot for the new one
        if (!valid_r || ready_i) begin
          data_r       <= shift_r;
          frame_err_r  <= !rx_i;
          parity_err_r <= par_err_r;
          valid_r      <= 1'b1;
        end else begin
          overrun_r    <= 1'b1;
        end
      end else if (valid_r && ready_i) begin
        valid_r <= 1'b0;
      end
    end
  end

  assign data_o       = data_r;
  assign frame_err_o  = frame_err_r;
  assign parity_err_o = parity_err_r;
  assign valid_o      = valid_r;
  assign overrun_o    = overrun_r;
  assign busy_o       = busy_r;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Scoreboard bench for uart_rx_frame: one receiver without parity, one with even parity,
// serial frames built from bit-level rules, words checked as they are handed over.
module tb_uart_rx_frame;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        rx_np, rx_p;
  logic [15:0] div_np, div_p;
  logic        ready_np, ready_p;
  logic [7:0]  data_np, data_p;
  logic        ferr_np, ferr_p, perr_np, perr_p;
  logic        valid_np, valid_p, ovr_np_o, ovr_p_o, busy_np, busy_p;

  uart_rx_frame #(.DATA_BITS(8), .DIV_WIDTH(16), .PARITY_EN(0), .PARITY_ODD(0)) dut_np (
    .clk_i(clk), .rst_i(rst), .rx_i(rx_np), .baud_div_i(div_np), .data_o(data_np),
    .frame_err_o(ferr_np), .parity_err_o(perr_np), .valid_o(valid_np), .ready_i(ready_np),
    .overrun_o(ovr_np_o), .busy_o(busy_np));

  uart_rx_frame #(.DATA_BITS(8), .DIV_WIDTH(16), .PARITY_EN(1), .PARITY_ODD(0)) dut_p (
    .clk_i(clk), .rst_i(rst), .rx_i(rx_p), .baud_div_i(div_p), .data_o(data_p),
    .frame_err_o(ferr_p), .parity_err_o(perr_p), .valid_o(valid_p), .ready_i(ready_p),
    .overrun_o(ovr_p_o), .busy_o(busy_p));

  typedef struct packed {
    logic [7:0] data;
    logic       ferr;
    logic       perr;
  } exp_t;

  exp_t q_np[$];
  exp_t q_p[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   ovr_np = 0, ovr_p = 0;
  int   busy_rise_np = 0, valid_rise_np = 0, busy_rise_p = 0, valid_rise_p = 0;
  logic busy_np_d = 1'b0, valid_np_d = 1'b0, busy_p_d = 1'b0, valid_p_d = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // monitor: pop the scoreboard whenever a word is handed over
  always @(negedge clk) begin
    exp_t e;
    if (busy_np === 1'b1 && busy_np_d !== 1'b1)   busy_rise_np  = cyc;
    if (valid_np === 1'b1 && valid_np_d !== 1'b1) valid_rise_np = cyc;
    if (busy_p === 1'b1 && busy_p_d !== 1'b1)     busy_rise_p   = cyc;
    if (valid_p === 1'b1 && valid_p_d !== 1'b1)   valid_rise_p  = cyc;
    busy_np_d = busy_np; valid_np_d = valid_np; busy_p_d = busy_p; valid_p_d = valid_p;
    if (rst === 1'b0) begin
      if (ovr_np_o === 1'b1) ovr_np++;
      if (ovr_p_o === 1'b1)  ovr_p++;
      if (valid_np === 1'b1 && ready_np === 1'b1) begin
        total++;
        if (q_np.size() == 0) begin
          bad++;
          $display("FAIL np_unexpected_word: got %0h expected none", data_np);
        end else begin
          e = q_np.pop_front();
          if ({data_np, ferr_np, perr_np} !== {e.data, e.ferr, e.perr}) begin
            bad++;
            $display("FAIL np_word: got data=%0h ferr=%0b perr=%0b expected data=%0h ferr=%0b perr=%0b",
                     data_np, ferr_np, perr_np, e.data, e.ferr, e.perr);
          end
        end
      end
      if (valid_p === 1'b1 && ready_p === 1'b1) begin
        total++;
        if (q_p.size() == 0) begin
          bad++;
          $display("FAIL p_unexpected_word: got %0h expected none", data_p);
        end else begin
          e = q_p.pop_front();
          if ({data_p, ferr_p, perr_p} !== {e.data, e.ferr, e.perr}) begin
            bad++;
            $display("FAIL p_word: got data=%0h ferr=%0b perr=%0b expected data=%0h ferr=%0b perr=%0b",
                     data_p, ferr_p, perr_p, e.data, e.ferr, e.perr);
          end
        end
      end
    end
  end

  task automatic wclk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input int sel, input logic v);
    if (sel == 0) rx_np = v;
    else          rx_p  = v;
  endtask

  // Serial frame: start, 8 data bits LSB first, parity (sel 1 only), stop; each bit 16*(div+1) clocks.
  task automatic send(input int sel, input logic [7:0] data, input logic pbit, input logic stop,
                      input int div, input int hold, input bit push, input bit scramble);
    int   bt;
    exp_t e;
    bt     = 16 * (div + 1);
    e.data = data;
    e.ferr = ~stop;
    e.perr = (sel == 1) ? logic'((($countones(data) + int'(pbit)) % 2) != 0) : 1'b0;
    if (push) begin
      if (sel == 0) q_np.push_back(e);
      else          q_p.push_back(e);
    end
    if (sel == 0) div_np = 16'(div);
    else          div_p  = 16'(div);
    drive(sel, 1'b0);
    if (scramble) begin
      wclk(3);
      if (sel == 0) div_np = 16'($urandom_range(0, 15));
      else          div_p  = 16'($urandom_range(0, 15));
      wclk(bt - 3);
    end else begin
      wclk(bt);
    end
    for (int i = 0; i < 8; i++) begin
      drive(sel, data[i]);
      wclk(bt);
    end
    if (sel == 1) begin
      drive(sel, pbit);
      wclk(bt);
    end
    drive(sel, stop);
    wclk(bt + hold);
    drive(sel, 1'b1);
    wclk(bt);
  endtask

  initial begin
    rst = 1'b1; rx_np = 1'b1; rx_p = 1'b1; div_np = 16'd3; div_p = 16'd3;
    ready_np = 1'b1; ready_p = 1'b1;
    wclk(5);
    check("rst_valid", {31'd0, valid_np}, 32'd0);
    check("rst_data",  {24'd0, data_np},  32'd0);
    check("rst_flags", {29'd0, ferr_np, perr_np, ovr_np_o}, 32'd0);
    check("rst_busy",  {30'd0, busy_np, busy_p}, 32'd0);
    check("rst_p_out", {22'd0, data_p, valid_p, ferr_p}, 32'd0);
    rst = 1'b0;
    wclk(5);

    // basic word, no parity, divider 3: valid 608 clocks after busy rises
    send(0, 8'hA5, 1'b0, 1'b1, 3, 0, 1'b1, 1'b0);
    check("np_latency", 32'(valid_rise_np - busy_rise_np), 32'd608);

    // even parity: wrong and right parity bits
    send(1, 8'h07, 1'b0, 1'b1, 3, 0, 1'b1, 1'b0);
    check("p_latency", 32'(valid_rise_p - busy_rise_p), 32'd672);
    send(1, 8'h07, 1'b1, 1'b1, 3, 0, 1'b1, 1'b0);

    // framing error then line held low 20 bit times: no retrigger
    send(0, 8'h3C, 1'b0, 1'b0, 3, 20 * 64, 1'b1, 1'b0);
    check("held_low_idle", {31'd0, busy_np}, 32'd0);

    // 20-clock glitch on idle line is rejected at the mid-start sample
    drive(0, 1'b0);
    wclk(20);
    check("glitch_busy", {31'd0, busy_np}, 32'd1);
    drive(0, 1'b1);
    wclk(40);
    check("glitch_idle", {31'd0, busy_np}, 32'd0);
    check("glitch_no_valid", {31'd0, valid_np}, 32'd0);

    // consumer stalled: second word dropped with one overrun pulse
    ready_np = 1'b0;
    send(0, 8'h11, 1'b0, 1'b1, 3, 0, 1'b1, 1'b0);
    send(0, 8'h22, 1'b0, 1'b1, 3, 0, 1'b0, 1'b0);
    check("ovr_held_data", {24'd0, data_np}, 32'h11);
    check("ovr_held_valid", {31'd0, valid_np}, 32'd1);
    check("ovr_pulse_cycles", 32'(ovr_np), 32'd1);
    ready_np = 1'b1;
    wclk(1);
    check("ovr_valid_drop", {31'd0, valid_np}, 32'd0);

    // reset during data bit 4 of 0xFF
    fork
      send(0, 8'hFF, 1'b0, 1'b1, 3, 0, 1'b0, 1'b0);
      begin
        wclk(330);
        rst = 1'b1;
        wclk(1);
        check("midrst_outs", {22'd0, data_np, valid_np, ferr_np}, 32'd0);
        check("midrst_flags", {29'd0, perr_np, ovr_np_o, busy_np}, 32'd0);
        rst = 1'b0;
      end
    join
    send(0, 8'h5A, 1'b0, 1'b1, 3, 0, 1'b1, 1'b0);

    // randomized frames on both receivers, divider changed after each start
    for (int n = 0; n < 16; n++) begin
      for (int s = 0; s < 2; s++) begin
        send(s, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
             logic'($urandom_range(0, 7) != 0), int'($urandom_range(0, 3)), 0, 1'b1, 1'b1);
      end
    end

    wclk(100);
    check("np_missing", 32'(q_np.size()), 32'd0);
    check("p_missing",  32'(q_p.size()),  32'd0);
    check("np_ovr_total", 32'(ovr_np), 32'd1);
    check("p_ovr_total",  32'(ovr_p),  32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
